dut_reg_arbiter: RTL and testbench
==================================

# dut_reg_arbiter

Two-master arbiter that shares the single register read/write port of the 8-entry register `dut` between two independent requesters. It sits between the requesters and the `dut` instance. It accepts one command per requester through a req/ack handshake and grants round-robin. It issues exactly one `write_en` or `read_en` pulse per granted command and returns read data with an ack pulse.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles from the `read_en` cycle until `dut_read_data` is valid. Legal range is 1..7.

Ports:
- `CLK` input 1: single clock; all logic is on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `req0`, `req1` input 1: command request from requester 0 / 1.
- `we0`, `we1` input 1: 1 = write, 0 = read. Qualified by `reqN`.
- `addr0`, `addr1` input 3: register address.
- `wdata0`, `wdata1` input 8: write data.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `rdata0`, `rdata1` output 8: read result. Valid in the ack cycle and held until that requester's next read ack.
- `busy` output 1: high in every non-IDLE state.
- `write_en` output 1: write strobe to `dut`.
- `write_address` output 3: write address to `dut`.
- `write_data` output 8: write data to `dut`.
- `read_en` output 1: read strobe to `dut`.
- `read_address` output 3: read address to `dut`.
- `dut_read_data` input 8: `dut` read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any `reqN` is high, select a winner, latch its `we`/`addr`/`wdata` and the winner id, then go to ISSUE.
  - If neither is high, stay in IDLE.
- Arbitration is round-robin:
  - A single request always wins.
  - On a tie, the requester not granted last wins.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
- ISSUE: exactly one cycle.
  - Write: `write_en`=1 with latched address and data, then go to RESP.
  - Read: `read_en`=1 with latched address, then go to WAIT.
  - Write and read strobes are never high together.
- WAIT: lasts READ_LATENCY cycles. In the last WAIT cycle, sample `dut_read_data` into `rdataN` of the winner, then go to RESP.
- RESP: `ackN`=1 for the winner only. Update `last` to the winner. Go to IDLE.
- Handshake rules:
  - A requester holds `req`/`we`/`addr`/`wdata` stable until it sees its ack, then drops or re-raises `req`.
  - A `req` still high in the IDLE cycle after an ack is treated as a new command.
  - The command is captured in IDLE. Dropping `req` after capture does not abort it: the command still executes and ack still pulses.
  - The non-winning requester's `rdata` is untouched.
- While the FSM is not in IDLE, input changes are ignored.

## Timing
Cycle 0 is the IDLE cycle in which `req` is seen high.
- Write: `write_en` in cycle 1; `ack` in cycle 2.
- Read: `read_en` in cycle 1; `dut_read_data` sampled in cycle 1+READ_LATENCY; `ack` in cycle 2+READ_LATENCY.
- Back-to-back commands: the next command's IDLE is the cycle after RESP.
  - Write throughput: 1 per 3 cycles.
  - Read throughput: 1 per 3+READ_LATENCY cycles.
- Reset values: all outputs are 0 (`ack0`, `ack1`, `rdata0`, `rdata1`, `busy`, both strobes, addresses, `write_data`). State is IDLE and `last` is 1.
- Reset asserted mid-command:
  - Outputs clear immediately (asynchronously), including any strobe in flight.
  - The aborted command is never acked.
  - After `RST` falls, the first possible strobe is 1 cycle after the first IDLE cycle that sees `req`.

## Configuration
- `DUT_ARB_STATS_EN` defined: adds outputs `grant_cnt0` and `grant_cnt1` (8 bits each).
  - Each counter increments in the winner's RESP cycle.
  - Each counter saturates at 255.
  - Both counters reset to 0 on `RST`.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Test plan
- Single write: `req0`=1, `we0`=1, `addr0`=3, `wdata0`=0xA5.
  - Expect `write_en`=1 with addr 3 and data 0xA5 in cycle 1, and `ack0` in cycle 2.
  - A follow-up read of addr 3 returns `rdata0`=0xA5 at cycle 2+READ_LATENCY.
- Tie:
  - `req0` and `req1` both held high from reset, issuing 4 commands. Expect grant order 0,1,0,1 and `ack0`/`ack1` alternating.
  - `grant_cnt0`=`grant_cnt1`=2 when `DUT_ARB_STATS_EN` is defined.
- Read latency sweep: READ_LATENCY=1 and 3; requester 1 reads addr 7 holding 0x3C.
  - Expect `ack1` in cycles 3 and 5 respectively, with `rdata1`=0x3C.
  - `rdata0` is unchanged.
- Early drop: `req0` is high for only cycle 0 (write, addr 1, data 0x11).
  - Expect `write_en` in cycle 1 and `ack0` in cycle 2.
  - The FSM then returns to IDLE with no further strobe.
- Reset mid-read: READ_LATENCY=3, assert `RST` in WAIT.
  - Expect all outputs 0 immediately and no `ack`.
  - After `RST` falls, with `req0` and `req1` both high, requester 0 wins.
- Stats saturation (macro on): 300 grants to requester 0. Expect `grant_cnt0`=255 and `grant_cnt1`=0.

Source files
------------

// File: rtl/dut_reg_arbiter.sv
// rtl/dut_reg_arbiter.sv - two-master round-robin arbiter for the dut register port
// Optional grant counters are compiled in with DUT_ARB_STATS_EN.
module dut_reg_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [2:0] addr0,
    input  logic [2:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic       write_en,
    output logic [2:0] write_address,
    output logic [7:0] write_data,
    output logic       read_en,
    output logic [2:0] read_address,
    input  logic [7:0] dut_read_data
`ifdef DUT_ARB_STATS_EN
    ,
    output logic [7:0] grant_cnt0,
    output logic [7:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    state_t     state, state_nxt;
    logic       win, win_nxt;
    logic       last, last_nxt;
    logic       cmd_we, cmd_we_nxt;
    logic [2:0] wait_cnt, wait_cnt_nxt;
    logic       pick;

    logic       ack0_nxt, ack1_nxt, busy_nxt;
    logic       write_en_nxt, read_en_nxt;
    logic [2:0] write_address_nxt, read_address_nxt;
    logic [7:0] write_data_nxt, rdata0_nxt, rdata1_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            win           <= 1'b0;
            last          <= 1'b1;
            cmd_we        <= 1'b0;
            wait_cnt      <= '0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            busy          <= 1'b0;
            write_en      <= 1'b0;
            read_en       <= 1'b0;
            write_address <= '0;
            read_address  <= '0;
            write_data    <= '0;
            rdata0        <= '0;
            rdata1        <= '0;
        end else begin
            state         <= state_nxt;
            win           <= win_nxt;
            last          <= last_nxt;
            cmd_we        <= cmd_we_nxt;
            wait_cnt      <= wait_cnt_nxt;
            ack0          <= ack0_nxt;
            ack1          <= ack1_nxt;
            busy          <= busy_nxt;
            write_en      <= write_en_nxt;
            read_en       <= read_en_nxt;
            write_address <= write_address_nxt;
            read_address  <= read_address_nxt;
            write_data    <= write_data_nxt;
            rdata0        <= rdata0_nxt;
            rdata1        <= rdata1_nxt;
        end
    end

    // Outputs are registered: each branch computes what the next state must present.
    always_comb begin
        state_nxt         = state;
        win_nxt           = win;
        last_nxt          = last;
        cmd_we_nxt        = cmd_we;
        wait_cnt_nxt      = wait_cnt;
        ack0_nxt          = 1'b0;
        ack1_nxt          = 1'b0;
        write_en_nxt      = 1'b0;
        read_en_nxt       = 1'b0;
        write_address_nxt = write_address;
        read_address_nxt  = read_address;
        write_data_nxt    = write_data;
        rdata0_nxt        = rdata0;
        rdata1_nxt        = rdata1;
        pick              = (req0 && req1) ? ~last : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win_nxt    = pick;
                    cmd_we_nxt = pick ? we1 : we0;
                    state_nxt  = ISSUE;
                    if (cmd_we_nxt) begin
                        write_en_nxt      = 1'b1;
                        write_address_nxt = pick ? addr1 : addr0;
                        write_data_nxt    = pick ? wdata1 : wdata0;
                    end else begin
                        read_en_nxt      = 1'b1;
                        read_address_nxt = pick ? addr1 : addr0;
                    end
                end
            end
            ISSUE: begin
                if (cmd_we) begin
                    state_nxt = RESP;
                    ack0_nxt  = ~win;
                    ack1_nxt  = win;
                end else begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WAIT_LAST;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    if (win) rdata1_nxt = dut_read_data;
                    else     rdata0_nxt = dut_read_data;
                    state_nxt = RESP;
                    ack0_nxt  = ~win;
                    ack1_nxt  = win;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            RESP: begin
                last_nxt  = win;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

`ifdef DUT_ARB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (state == RESP) begin
            if (!win && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
            if (win && grant_cnt1 != 8'hFF)  grant_cnt1 <= grant_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dut_reg_arbiter.sv
// tb/tb_dut_reg_arbiter.sv - self-checking bench for dut_reg_arbiter at READ_LATENCY 1 and 3
module tb_dut_reg_arbiter;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic       req0 [2], req1 [2], we0 [2], we1 [2];
    logic [2:0] addr0 [2], addr1 [2];
    logic [7:0] wdata0 [2], wdata1 [2];
    logic       ack0 [2], ack1 [2], busy [2], write_en [2], read_en [2];
    logic [2:0] write_address [2], read_address [2];
    logic [7:0] write_data [2], rdata0 [2], rdata1 [2], dut_read_data [2];
`ifdef DUT_ARB_STATS_EN
    logic [7:0] grant_cnt0 [2], grant_cnt1 [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dut_reg_arbiter #(.READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .CLK(CLK), .RST(RST),
            .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
            .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
            .ack0(ack0[g]), .ack1(ack1[g]), .rdata0(rdata0[g]), .rdata1(rdata1[g]),
            .busy(busy[g]), .write_en(write_en[g]), .write_address(write_address[g]),
            .write_data(write_data[g]), .read_en(read_en[g]), .read_address(read_address[g]),
            .dut_read_data(dut_read_data[g])
`ifdef DUT_ARB_STATS_EN
            , .grant_cnt0(grant_cnt0[g]), .grant_cnt1(grant_cnt1[g])
`endif
        );
    end

    // Register file behind each arbiter, with its own read latency.
    logic [7:0] mem [2][8];
    logic [7:0] pipe [2][1:7];
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (write_en[k]) mem[k][write_address[k]] <= write_data[k];
            pipe[k][1] <= read_en[k] ? mem[k][read_address[k]] : 8'hEE;
            for (int j = 2; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end
    assign dut_read_data[0] = pipe[0][1];
    assign dut_read_data[1] = pipe[1][3];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_rd [2][2];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (lat%0d): got %0h, expected %0h", name, lat(k), act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cmd(input int k, input int r, input logic rq, input logic we,
                           input logic [2:0] addr, input logic [7:0] data);
        if (r == 0) begin
            req0[k] = rq; we0[k] = we; addr0[k] = addr; wdata0[k] = data;
        end else begin
            req1[k] = rq; we1[k] = we; addr1[k] = addr; wdata1[k] = data;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            set_cmd(k, 0, 1'b0, 1'b0, 3'd0, 8'd0);
            set_cmd(k, 1, 1'b0, 1'b0, 3'd0, 8'd0);
        end
    endtask

    task automatic chk_zero(input string name, input int k);
        chk({name, "_busy"}, k, busy[k], 0);
        chk({name, "_acks"}, k, {ack1[k], ack0[k]}, 0);
        chk({name, "_strobes"}, k, {write_en[k], read_en[k]}, 0);
        chk({name, "_addrs"}, k, {write_address[k], read_address[k]}, 0);
        chk({name, "_wdata"}, k, write_data[k], 0);
        chk({name, "_rdata"}, k, {rdata1[k], rdata0[k]}, 0);
    endtask

    typedef struct {
        int         rq;
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic       early_drop;
        logic [7:0] exp_rdata;
        int         ack_l1;
        int         ack_l3;
    } vec_t;

    vec_t vecs [8];

    task automatic apply_cmd(input int i, input vec_t v);
        int nstb [2];
        int stb_c [2];
        int nack [2];
        int ack_c [2];
        for (int k = 0; k < 2; k++) begin
            nstb[k] = 0; stb_c[k] = -1; nack[k] = 0; ack_c[k] = -1;
            set_cmd(k, v.rq, 1'b1, v.we, v.addr, v.wdata);
        end
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            for (int k = 0; k < 2; k++) begin
                if (write_en[k] || read_en[k]) begin
                    nstb[k]++;
                    stb_c[k] = c;
                    chk($sformatf("v%0d_strobe_kind", i), k, {write_en[k], read_en[k]}, v.we ? 2'b10 : 2'b01);
                    chk($sformatf("v%0d_strobe_addr", i), k, v.we ? write_address[k] : read_address[k], v.addr);
                    if (v.we) chk($sformatf("v%0d_strobe_data", i), k, write_data[k], v.wdata);
                end
                if (ack0[k] || ack1[k]) begin
                    nack[k]++;
                    ack_c[k] = c;
                    chk($sformatf("v%0d_ack_id", i), k, {ack1[k], ack0[k]}, (v.rq == 1) ? 2'b10 : 2'b01);
                    if (!v.we) exp_rd[k][v.rq] = v.exp_rdata;
                    if (v.rq == 0) req0[k] = 1'b0; else req1[k] = 1'b0;
                end
                if (c == 1 && v.early_drop) begin
                    if (v.rq == 0) req0[k] = 1'b0; else req1[k] = 1'b0;
                end
                chk($sformatf("v%0d_rdata0", i), k, rdata0[k], exp_rd[k][0]);
                chk($sformatf("v%0d_rdata1", i), k, rdata1[k], exp_rd[k][1]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("v%0d_num_strobes", i), k, nstb[k], 1);
            chk($sformatf("v%0d_strobe_cycle", i), k, stb_c[k], 1);
            chk($sformatf("v%0d_num_acks", i), k, nack[k], 1);
            chk($sformatf("v%0d_ack_cycle", i), k, ack_c[k], (k == 0) ? v.ack_l1 : v.ack_l3);
            chk($sformatf("v%0d_busy_end", i), k, busy[k], 0);
        end
    endtask

    // Transaction-level reference for the randomized run.
    logic       m_cur_v [2], m_we [2], m_w [2], m_last [2];
    int         m_t0 [2], m_ack [2], m_next_idle [2], ndone0 [2];
    logic [2:0] m_addr [2];
    logic [7:0] m_data [2], m_rval [2];
    logic [7:0] ref_mem [2][8];
    logic       pend [2][2];

    task automatic model_step(input int k, input int t);
        logic e_wr, e_rd, e_ack, w, a;
        e_wr  = m_cur_v[k] && m_we[k] && (t == m_t0[k] + 1);
        e_rd  = m_cur_v[k] && !m_we[k] && (t == m_t0[k] + 1);
        e_ack = m_cur_v[k] && (t == m_ack[k]);
        if (e_ack && !m_we[k]) exp_rd[k][m_w[k]] = m_rval[k];
        chk("rnd_write_en", k, write_en[k], e_wr);
        chk("rnd_read_en", k, read_en[k], e_rd);
        chk("rnd_ack0", k, ack0[k], e_ack && !m_w[k]);
        chk("rnd_ack1", k, ack1[k], e_ack && m_w[k]);
        chk("rnd_busy", k, busy[k], m_cur_v[k] && (t > m_t0[k]));
        chk("rnd_rdata0", k, rdata0[k], exp_rd[k][0]);
        chk("rnd_rdata1", k, rdata1[k], exp_rd[k][1]);
        if (e_wr) begin
            chk("rnd_write_address", k, write_address[k], m_addr[k]);
            chk("rnd_write_data", k, write_data[k], m_data[k]);
        end
        if (e_rd) chk("rnd_read_address", k, read_address[k], m_addr[k]);
        if (e_ack) m_cur_v[k] = 1'b0;

        for (int r = 0; r < 2; r++) begin
            a = (r == 0) ? ack0[k] : ack1[k];
            if (pend[k][r] && a) begin
                pend[k][r] = 1'b0;
                if (r == 0) ndone0[k]++;
            end
            if (!pend[k][r]) begin
                if ($urandom_range(0, 99) < 55 && (r == 0 || ndone0[k] >= 8)) begin
                    if (r == 0 && ndone0[k] < 8)
                        set_cmd(k, 0, 1'b1, 1'b1, 3'(ndone0[k]), 8'($urandom_range(0, 255)));
                    else
                        set_cmd(k, r, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                                8'($urandom_range(0, 255)));
                    pend[k][r] = 1'b1;
                end else if (r == 0) begin
                    req0[k] = 1'b0;
                end else begin
                    req1[k] = 1'b0;
                end
            end
        end

        if (!m_cur_v[k] && t >= m_next_idle[k] && (req0[k] || req1[k])) begin
            w = (req0[k] && req1[k]) ? !m_last[k] : req1[k];
            m_cur_v[k] = 1'b1;
            m_t0[k]    = t;
            m_w[k]     = w;
            m_we[k]    = w ? we1[k] : we0[k];
            m_addr[k]  = w ? addr1[k] : addr0[k];
            m_data[k]  = w ? wdata1[k] : wdata0[k];
            m_last[k]  = w;
            if (m_we[k]) begin
                ref_mem[k][m_addr[k]] = m_data[k];
                m_ack[k]       = t + 2;
                m_next_idle[k] = t + 3;
            end else begin
                m_rval[k]      = ref_mem[k][m_addr[k]];
                m_ack[k]       = t + 2 + lat(k);
                m_next_idle[k] = t + 3 + lat(k);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [2];
        int nack [2];
        int nstb [2];
        int stb_c [2];
        int stb_a [2];
        int ack_c0 [2];
        int ack_c1 [2];

        vecs[0] = '{0, 1'b1, 3'd3, 8'hA5, 1'b0, 8'h00, 2, 2};
        vecs[1] = '{0, 1'b0, 3'd3, 8'h00, 1'b0, 8'hA5, 3, 5};
        vecs[2] = '{1, 1'b1, 3'd7, 8'h3C, 1'b0, 8'h00, 2, 2};
        vecs[3] = '{1, 1'b0, 3'd7, 8'h00, 1'b0, 8'h3C, 3, 5};
        vecs[4] = '{0, 1'b1, 3'd1, 8'h11, 1'b1, 8'h00, 2, 2};
        vecs[5] = '{0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h11, 3, 5};
        vecs[6] = '{1, 1'b0, 3'd3, 8'h00, 1'b0, 8'hA5, 3, 5};
        vecs[7] = '{0, 1'b0, 3'd7, 8'h00, 1'b0, 8'h3C, 3, 5};

        // Tie: both requesters hold writes from reset.
        RST = 1'b1;
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            set_cmd(k, 0, 1'b1, 1'b1, 3'd2, 8'h20);
            set_cmd(k, 1, 1'b1, 1'b1, 3'd5, 8'h50);
            seq[k] = '0; nack[k] = 0; nstb[k] = 0;
            exp_rd[k][0] = '0; exp_rd[k][1] = '0;
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) chk_zero("reset", k);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (write_en[k]) begin
                    nstb[k]++;
                    chk("tie_strobe_addr", k, write_address[k], (nstb[k] % 2 == 1) ? 32'd2 : 32'd5);
                end
                if (ack0[k] || ack1[k]) begin
                    chk("tie_ack_cycle", k, c, 2 + 3 * nack[k]);
                    seq[k] = {seq[k][6:0], ack1[k]};
                    nack[k]++;
                    if (nack[k] == 4) begin
                        req0[k] = 1'b0;
                        req1[k] = 1'b0;
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("tie_order", k, seq[k], 8'b0000_0101);
            chk("tie_num_acks", k, nack[k], 4);
            chk("tie_num_strobes", k, nstb[k], 4);
`ifdef DUT_ARB_STATS_EN
            chk("tie_grant_cnt0", k, grant_cnt0[k], 2);
            chk("tie_grant_cnt1", k, grant_cnt1[k], 2);
`endif
        end

        for (int i = 0; i < 8; i++) apply_cmd(i, vecs[i]);

        // Reset during a read: abort, clear at once, then requester 0 wins the tie.
        for (int k = 0; k < 2; k++) set_cmd(k, 0, 1'b1, 1'b0, 3'd3, 8'h00);
        tick();
        for (int k = 0; k < 2; k++) chk("rst_read_en", k, read_en[k], 1);
        tick();
        for (int k = 0; k < 2; k++) chk("rst_busy_wait", k, busy[k], 1);
        #2;
        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_cmd(k, 0, 1'b1, 1'b1, 3'd4, 8'h44);
            set_cmd(k, 1, 1'b1, 1'b1, 3'd6, 8'h66);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_zero("rst_async", k);
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
        end
        repeat (2) begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < 2; k++) chk("rst_hold_acks", k, {ack1[k], ack0[k]}, 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stb_c[k] = -1; stb_a[k] = -1; ack_c0[k] = -1; ack_c1[k] = -1;
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (write_en[k] && stb_c[k] < 0) begin
                    stb_c[k] = c;
                    stb_a[k] = int'(write_address[k]);
                end
                if (ack0[k]) begin ack_c0[k] = c; req0[k] = 1'b0; end
                if (ack1[k]) begin ack_c1[k] = c; req1[k] = 1'b0; end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("rst_first_strobe_cycle", k, stb_c[k], 1);
            chk("rst_first_strobe_addr", k, stb_a[k], 4);
            chk("rst_ack0_cycle", k, ack_c0[k], 2);
            chk("rst_ack1_cycle", k, ack_c1[k], 5);
            chk("rst_rdata0", k, rdata0[k], 0);
        end

`ifdef DUT_ARB_STATS_EN
        clear_inputs();
        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_cmd(k, 0, 1'b1, 1'b1, 3'd0, 8'h5A);
            nack[k] = 0;
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (ack0[k]) begin
                    nack[k]++;
                    if (nack[k] == 300) req0[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("sat_grants", k, nack[k], 300);
            chk("sat_grant_cnt0", k, grant_cnt0[k], 255);
            chk("sat_grant_cnt1", k, grant_cnt1[k], 0);
        end
`endif

        // Randomized traffic against the transaction-level model.
        clear_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            m_cur_v[k] = 1'b0; m_last[k] = 1'b1; m_next_idle[k] = 0; ndone0[k] = 0;
            m_t0[k] = -10; m_ack[k] = -10; m_we[k] = 1'b0; m_w[k] = 1'b0;
            exp_rd[k][0] = '0; exp_rd[k][1] = '0;
            pend[k][0] = 1'b0; pend[k][1] = 1'b0;
        end
        for (int t = 0; t < 2500; t++) begin
            if (t > 0) tick();
            for (int k = 0; k < 2; k++) model_step(k, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
